// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller.
// Holds the load/store type codes, FSM state encoding, the latched request
// payload and small helpers for the byte count and the IO address predicate.
package mem_ctrl_pkg;

    localparam int unsigned ROB_SIZE_WIDTH_DEF   = 5;
    localparam int unsigned LOAD_TYPE_NUM_WIDTH  = 3;
    localparam int unsigned STORE_TYPE_NUM_WIDTH = 2;
    localparam int unsigned ADDR_W               = 32;
    localparam int unsigned DATA_W               = 32;

    // Load funct3 codes
    localparam logic [LOAD_TYPE_NUM_WIDTH-1:0] LT_LB  = 3'b000;
    localparam logic [LOAD_TYPE_NUM_WIDTH-1:0] LT_LH  = 3'b001;
    localparam logic [LOAD_TYPE_NUM_WIDTH-1:0] LT_LW  = 3'b010;
    localparam logic [LOAD_TYPE_NUM_WIDTH-1:0] LT_LBU = 3'b100;
    localparam logic [LOAD_TYPE_NUM_WIDTH-1:0] LT_LHU = 3'b101;

    // Store type codes, shared with the ROB
    localparam logic [STORE_TYPE_NUM_WIDTH-1:0] ST_SB = 2'b00;
    localparam logic [STORE_TYPE_NUM_WIDTH-1:0] ST_SH = 2'b01;
    localparam logic [STORE_TYPE_NUM_WIDTH-1:0] ST_SW = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STORE = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Request latched at accept; kind is the load funct3 or {0, store type}
    typedef struct packed {
        logic [ADDR_W-1:0]              addr;
        logic [DATA_W-1:0]              data;
        logic [LOAD_TYPE_NUM_WIDTH-1:0] kind;
    } req_t;

    // Index of the last byte for a given size code (1/2/4 bytes)
    function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
        case (size)
            ST_SB:   return 2'd0;
            ST_SH:   return 2'd1;
            ST_SW:   return 2'd3;
            default: return 2'd3;
        endcase
    endfunction

    // UART window: address bits [17:16] both set
    function automatic logic is_io_addr(input logic [ADDR_W-1:0] addr);
        return addr[17:16] == 2'b11;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational sign/zero extender for load results.
// Ports: load_type (funct3), raw (assembled little-endian bytes),
//        value (extended 32-bit result).
module load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [LOAD_TYPE_NUM_WIDTH-1:0] load_type,
    input  logic [DATA_W-1:0]              raw,
    output logic [DATA_W-1:0]              value
);

    always_comb begin
        value = raw;
        case (load_type)
            LT_LB:   value = {{24{raw[7]}}, raw[7:0]};
            LT_LH:   value = {{16{raw[15]}}, raw[15:0]};
            LT_LW:   value = raw;
            LT_LBU:  value = {24'd0, raw[7:0]};
            LT_LHU:  value = {16'd0, raw[15:0]};
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: accepts committed stores from the ROB and
// load requests from the LSB and sequences them onto the 8-bit RAM/IO port.
// Ports: clk_in/rst_in (async active-low)/rdy_in (global enable),
//        need_flush_in, ROB store commit (rob2mem_ready, store_type_in,
//        data_addr_in, value_in), LSB load request (lsb_load_*),
//        load result (mem_valid, mem_dependency, mem_value), mem_busy,
//        RAM port (mem_din, mem_dout, mem_a, mem_wr), io_buffer_full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ROB_SIZE_WIDTH = ROB_SIZE_WIDTH_DEF
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            need_flush_in,
    input  logic                            rob2mem_ready,
    input  logic [STORE_TYPE_NUM_WIDTH-1:0] store_type_in,
    input  logic [ADDR_W-1:0]               data_addr_in,
    input  logic [DATA_W-1:0]               value_in,
    input  logic                            lsb_load_valid,
    input  logic [LOAD_TYPE_NUM_WIDTH-1:0]  lsb_load_type,
    input  logic [ADDR_W-1:0]               lsb_load_addr,
    input  logic [ROB_SIZE_WIDTH:0]         lsb_load_dependency,
    output logic                            mem_busy,
    output logic                            mem_valid,
    output logic [ROB_SIZE_WIDTH:0]         mem_dependency,
    output logic [DATA_W-1:0]               mem_value,
    input  logic [7:0]                      mem_din,
    output logic [7:0]                      mem_dout,
    output logic [ADDR_W-1:0]               mem_a,
    output logic                            mem_wr,
    input  logic                            io_buffer_full
);

    state_t                  state, state_nx;
    logic [1:0]              cnt, cnt_nx;
    logic                    tail, tail_nx;     // all load addresses issued
    req_t                    req, req_nx;
    logic [ROB_SIZE_WIDTH:0] tag, tag_nx;
    logic [DATA_W-1:0]       load_buf, buf_nx;
    logic                    valid_nx;
    logic [ROB_SIZE_WIDTH:0] dep_nx;
    logic [DATA_W-1:0]       value_nx;

    logic                    last;
    logic                    io_stall;
    logic [1:0]              cap_idx;
    logic [DATA_W-1:0]       buf_cap;
    logic [DATA_W-1:0]       ext_value;

    assign mem_busy = (state != S_IDLE) | rob2mem_ready;
    assign last     = (cnt == last_byte_idx(req.kind[1:0]));
    assign io_stall = is_io_addr(req.addr) & io_buffer_full;
    // Data for the address issued last cycle lands in byte cnt-1 (wraps to 3)
    assign cap_idx  = cnt - 2'd1;

    // Load buffer with the byte arriving this cycle merged in
    always_comb begin
        buf_cap = load_buf;
        buf_cap[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    load_extend u_load_extend (
        .load_type (req.kind),
        .raw       (buf_cap),
        .value     (ext_value)
    );

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= S_IDLE;
            cnt            <= 2'd0;
            tail           <= 1'b0;
            req            <= '0;
            tag            <= '0;
            load_buf       <= '0;
            mem_valid      <= 1'b0;
            mem_dependency <= '0;
            mem_value      <= '0;
        end else if (rdy_in) begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            tail           <= tail_nx;
            req            <= req_nx;
            tag            <= tag_nx;
            load_buf       <= buf_nx;
            mem_valid      <= valid_nx;
            mem_dependency <= dep_nx;
            mem_value      <= value_nx;
        end
    end

    // Next-state and RAM port drive
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tail_nx  = tail;
        req_nx   = req;
        tag_nx   = tag;
        buf_nx   = load_buf;
        valid_nx = 1'b0;
        dep_nx   = mem_dependency;
        value_nx = mem_value;
        mem_wr   = 1'b0;
        mem_a    = '0;
        mem_dout = '0;

        case (state)
            S_IDLE: begin
                if (rob2mem_ready) begin
                    state_nx = S_STORE;
                    cnt_nx   = 2'd0;
                    req_nx   = '{addr: data_addr_in, data: value_in,
                                 kind: {1'b0, store_type_in}};
                end else if (lsb_load_valid && !mem_valid && !need_flush_in) begin
                    state_nx = S_LOAD;
                    cnt_nx   = 2'd0;
                    tail_nx  = 1'b0;
                    req_nx   = '{addr: lsb_load_addr, data: '0,
                                 kind: lsb_load_type};
                    tag_nx   = lsb_load_dependency;
                    buf_nx   = '0;
                end
            end

            // Committed store: flush is ignored
            S_STORE: begin
                mem_a    = req.addr + 32'(cnt);
                mem_dout = req.data[{cnt, 3'b000} +: 8];
                mem_wr   = rdy_in & ~io_stall;
                if (!io_stall) begin
                    if (last) begin
                        state_nx = S_IDLE;
                        cnt_nx   = 2'd0;
                    end else begin
                        cnt_nx = cnt + 2'd1;
                    end
                end
            end

            S_LOAD: begin
                if (!tail) begin
                    mem_a = req.addr + 32'(cnt);
                end
                if (tail || cnt != 2'd0) begin
                    buf_nx = buf_cap;
                end
                if (need_flush_in) begin
                    state_nx = S_IDLE;
                    cnt_nx   = 2'd0;
                    tail_nx  = 1'b0;
                end else if (tail) begin
                    state_nx = S_DONE;
                    cnt_nx   = 2'd0;
                    tail_nx  = 1'b0;
                    valid_nx = 1'b1;
                    dep_nx   = tag;
                    value_nx = ext_value;
                end else begin
                    if (last) begin
                        tail_nx = 1'b1;
                    end
                    cnt_nx = cnt + 2'd1;
                end
            end

            S_DONE: begin
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table-driven load and store vectors plus
// hand-written sequences for IO stall, flush, rdy freeze, same-cycle
// store/load and asynchronous reset.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        need_flush_in;
    logic        rob2mem_ready;
    logic [1:0]  store_type_in;
    logic [31:0] data_addr_in;
    logic [31:0] value_in;
    logic        lsb_load_valid;
    logic [2:0]  lsb_load_type;
    logic [31:0] lsb_load_addr;
    logic [5:0]  lsb_load_dependency;
    logic        mem_busy;
    logic        mem_valid;
    logic [5:0]  mem_dependency;
    logic [31:0] mem_value;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int vec_cnt = 0;
    int err_cnt = 0;

    mem_ctrl #(.ROB_SIZE_WIDTH(5)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .need_flush_in       (need_flush_in),
        .rob2mem_ready       (rob2mem_ready),
        .store_type_in       (store_type_in),
        .data_addr_in        (data_addr_in),
        .value_in            (value_in),
        .lsb_load_valid      (lsb_load_valid),
        .lsb_load_type       (lsb_load_type),
        .lsb_load_addr       (lsb_load_addr),
        .lsb_load_dependency (lsb_load_dependency),
        .mem_busy            (mem_busy),
        .mem_valid           (mem_valid),
        .mem_dependency      (mem_dependency),
        .mem_value           (mem_value),
        .mem_din             (mem_din),
        .mem_dout            (mem_dout),
        .mem_a               (mem_a),
        .mem_wr              (mem_wr),
        .io_buffer_full      (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: 4 KiB window, synchronous write, read data one cycle later
    logic [7:0]  ram [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_word = '0;

    always @(posedge clk_in) begin
        if (pre_we) begin
            for (int i = 0; i < 4; i++) begin
                ram[pre_addr + 12'(i)] <= pre_word[8*i +: 8];
            end
        end else if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[11:0]];
    end

    typedef struct {
        logic [2:0]  ltype;
        logic [31:0] addr;
        logic [31:0] ram_word;
        logic [5:0]  tag;
        logic [31:0] exp_value;
        int          exp_cycle;
    } load_vec_t;

    typedef struct {
        logic [1:0]  stype;
        logic [31:0] addr;
        logic [31:0] data;
        logic        flush;
        int          exp_n;
        logic [31:0] exp_a [4];
        logic [7:0]  exp_b [4];
    } store_vec_t;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_store(input store_vec_t v);
        rob2mem_ready = 1'b1;
        store_type_in = v.stype;
        data_addr_in  = v.addr;
        value_in      = v.data;
        #1;
        chk("store_pulse_busy", 32'(mem_busy), 32'd1);
        step();
        rob2mem_ready = 1'b0;
        need_flush_in = v.flush;
        for (int k = 0; k < v.exp_n; k++) begin
            #1;
            chk("store_wr",   32'(mem_wr),   32'd1);
            chk("store_a",    mem_a,         v.exp_a[k]);
            chk("store_dout", 32'(mem_dout), 32'(v.exp_b[k]));
            chk("store_busy", 32'(mem_busy), 32'd1);
            step();
        end
        need_flush_in = 1'b0;
        #1;
        chk("store_end_wr",   32'(mem_wr),   32'd0);
        chk("store_end_busy", 32'(mem_busy), 32'd0);
        step();
    endtask

    task automatic run_load(input load_vec_t v);
        int cyc;
        int pulses;
        pre_addr = v.addr[11:0];
        pre_word = v.ram_word;
        pre_we   = 1'b1;
        step();
        pre_we              = 1'b0;
        lsb_load_valid      = 1'b1;
        lsb_load_type       = v.ltype;
        lsb_load_addr       = v.addr;
        lsb_load_dependency = v.tag;
        #1;
        chk("load_req_busy", 32'(mem_busy), 32'd0);
        step();
        cyc = 1;
        while (!mem_valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk("load_valid_cycle", 32'(cyc),            32'(v.exp_cycle));
        chk("load_value",       mem_value,           v.exp_value);
        chk("load_dep",         32'(mem_dependency), 32'(v.tag));
        lsb_load_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_valid) pulses++;
        end
        chk("load_valid_once", 32'(pulses),   32'd0);
        chk("load_idle_busy",  32'(mem_busy), 32'd0);
    endtask

    load_vec_t  lv [6];
    store_vec_t sv [4];

    initial begin
        // Load vectors: RAM word is little-endian at addr..addr+3
        lv[0] = '{3'b000, 32'h200, 32'h0000_0080, 6'd5,  32'hFFFF_FF80, 3};
        lv[1] = '{3'b100, 32'h200, 32'h0000_0080, 6'd6,  32'h0000_0080, 3};
        lv[2] = '{3'b001, 32'h210, 32'h0000_8001, 6'd33, 32'hFFFF_8001, 4};
        lv[3] = '{3'b101, 32'h210, 32'h0000_8001, 6'd34, 32'h0000_8001, 4};
        lv[4] = '{3'b010, 32'h220, 32'hDEAD_BEEF, 6'd63, 32'hDEAD_BEEF, 6};
        lv[5] = '{3'b000, 32'h230, 32'h1234_567F, 6'd1,  32'h0000_007F, 3};

        sv[0] = '{2'b10, 32'h0000_0100, 32'h1234_5678, 1'b0, 4,
                  '{32'h100, 32'h101, 32'h102, 32'h103}, '{8'h78, 8'h56, 8'h34, 8'h12}};
        sv[1] = '{2'b01, 32'h0000_0500, 32'h0000_BEEF, 1'b1, 2,
                  '{32'h500, 32'h501, 32'h0, 32'h0}, '{8'hEF, 8'hBE, 8'h00, 8'h00}};
        sv[2] = '{2'b00, 32'h0000_0600, 32'hFFFF_FF5A, 1'b0, 1,
                  '{32'h600, 32'h0, 32'h0, 32'h0}, '{8'h5A, 8'h00, 8'h00, 8'h00}};
        sv[3] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0, 2,
                  '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0}, '{8'h34, 8'h12, 8'h00, 8'h00}};

        rst_in              = 1'b0;
        rdy_in              = 1'b1;
        need_flush_in       = 1'b0;
        rob2mem_ready       = 1'b0;
        store_type_in       = '0;
        data_addr_in        = '0;
        value_in            = '0;
        lsb_load_valid      = 1'b0;
        lsb_load_type       = '0;
        lsb_load_addr       = '0;
        lsb_load_dependency = '0;
        io_buffer_full      = 1'b0;

        // Reset state
        #2;
        chk("rst_valid", 32'(mem_valid),      32'd0);
        chk("rst_dep",   32'(mem_dependency), 32'd0);
        chk("rst_value", mem_value,           32'd0);
        chk("rst_wr",    32'(mem_wr),         32'd0);
        chk("rst_a",     mem_a,               32'd0);
        chk("rst_dout",  32'(mem_dout),       32'd0);
        chk("rst_busy",  32'(mem_busy),       32'd0);
        rob2mem_ready = 1'b1;
        #1;
        chk("rst_busy_pulse", 32'(mem_busy), 32'd1);
        rob2mem_ready = 1'b0;
        step();
        rst_in = 1'b1;
        step();

        foreach (sv[i]) run_store(sv[i]);
        foreach (lv[i]) run_load(lv[i]);

        // IO stall: SB 0x41 to UART window with buffer full for 3 cycles
        rob2mem_ready  = 1'b1;
        store_type_in  = 2'b00;
        data_addr_in   = 32'h0003_0000;
        value_in       = 32'h0000_0041;
        io_buffer_full = 1'b1;
        step();
        rob2mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("io_stall_wr",   32'(mem_wr),   32'd0);
            chk("io_stall_busy", 32'(mem_busy), 32'd1);
            step();
        end
        io_buffer_full = 1'b0;
        #1;
        chk("io_wr",   32'(mem_wr),   32'd1);
        chk("io_a",    mem_a,         32'h0003_0000);
        chk("io_dout", 32'(mem_dout), 32'h41);
        step();
        #1;
        chk("io_end_wr",   32'(mem_wr),   32'd0);
        chk("io_end_busy", 32'(mem_busy), 32'd0);
        step();

        // Flush during the second LW address cycle
        lsb_load_valid      = 1'b1;
        lsb_load_type       = 3'b010;
        lsb_load_addr       = 32'h240;
        lsb_load_dependency = 6'd7;
        step();
        step();
        need_flush_in  = 1'b1;
        lsb_load_valid = 1'b0;
        #1;
        chk("flush_a2", mem_a, 32'h241);
        step();
        need_flush_in = 1'b0;
        #1;
        chk("flush_idle_busy", 32'(mem_busy), 32'd0);
        chk("flush_idle_a",    mem_a,         32'd0);
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 6; i++) begin
                if (mem_valid) pulses++;
                step();
            end
            chk("flush_no_valid", 32'(pulses), 32'd0);
        end

        // Store and load in the same cycle: store runs first, load sees it
        rob2mem_ready       = 1'b1;
        store_type_in       = 2'b10;
        data_addr_in        = 32'h300;
        value_in            = 32'hCAFE_F00D;
        lsb_load_valid      = 1'b1;
        lsb_load_type       = 3'b010;
        lsb_load_addr       = 32'h300;
        lsb_load_dependency = 6'd9;
        step();
        rob2mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("sl_store_wr", 32'(mem_wr), 32'd1);
            chk("sl_store_a",  mem_a,       32'h300 + 32'(k));
            step();
        end
        #1;
        chk("sl_gap_busy", 32'(mem_busy), 32'd0);
        begin
            int cyc;
            step();
            cyc = 1;
            while (!mem_valid && cyc < 20) begin
                step();
                cyc++;
            end
            chk("sl_valid_cycle", 32'(cyc),            32'd6);
            chk("sl_value",       mem_value,           32'hCAFE_F00D);
            chk("sl_dep",         32'(mem_dependency), 32'd9);
        end
        lsb_load_valid = 1'b0;
        step();
        #1;
        chk("sl_valid_drop", 32'(mem_valid), 32'd0);
        step();

        // rdy_in freeze mid-SW
        rob2mem_ready = 1'b1;
        store_type_in = 2'b10;
        data_addr_in  = 32'h400;
        value_in      = 32'hA1B2_C3D4;
        step();
        rob2mem_ready = 1'b0;
        #1;
        chk("rdy_w0_a", mem_a, 32'h400);
        step();
        rdy_in = 1'b0;
        #1;
        chk("rdy_frz_wr", 32'(mem_wr), 32'd0);
        step();
        step();
        #1;
        chk("rdy_frz_wr2", 32'(mem_wr), 32'd0);
        chk("rdy_frz_a",   mem_a,       32'h401);
        rdy_in = 1'b1;
        #1;
        chk("rdy_res_wr",   32'(mem_wr),   32'd1);
        chk("rdy_res_dout", 32'(mem_dout), 32'hC3);
        step();
        #1;
        chk("rdy_w2_a", mem_a, 32'h402);
        step();
        #1;
        chk("rdy_w3_dout", 32'(mem_dout), 32'hA1);
        step();
        #1;
        chk("rdy_end_busy", 32'(mem_busy), 32'd0);
        step();

        // Asynchronous reset in the middle of a SW
        rob2mem_ready = 1'b1;
        store_type_in = 2'b10;
        data_addr_in  = 32'h700;
        value_in      = 32'h1122_3344;
        step();
        rob2mem_ready = 1'b0;
        step();
        #1;
        chk("arst_pre_wr", 32'(mem_wr), 32'd1);
        #1;
        rst_in = 1'b0;
        #1;
        chk("arst_wr",   32'(mem_wr),   32'd0);
        chk("arst_a",    mem_a,         32'd0);
        chk("arst_dout", 32'(mem_dout), 32'd0);
        chk("arst_busy", 32'(mem_busy), 32'd0);
        step();
        #2;
        rst_in = 1'b1;
        begin
            int writes;
            int busy_cnt;
            writes   = 0;
            busy_cnt = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                #1;
                if (mem_wr) writes++;
                if (mem_busy) busy_cnt++;
            end
            chk("arst_no_writes", 32'(writes),   32'd0);
            chk("arst_no_busy",   32'(busy_cnt), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
